// File: rtl/fft_pkg.sv
// fft_pkg: shared frame-reader constants, sample/frame types and reader state enum
package fft_pkg;
    localparam int N_PTS    = 128;
    localparam int LOG2_N   = 7;
    localparam int SAMPLE_W = 8;
    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t [N_PTS-1:0] frame_t;
    typedef logic [LOG2_N-1:0]   idx_t;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} rd_state_t;
endpackage

// File: rtl/fft_index_map.sv
// fft_index_map: beat index to time index; bit-reversed when BITREV_ORDER_EN is defined, identity otherwise
module fft_index_map
    import fft_pkg::*;
(
    input  logic [LOG2_N-1:0] k_i,
    output logic [LOG2_N-1:0] n_o
);
`ifdef BITREV_ORDER_EN
    for (genvar i = 0; i < LOG2_N; i++) begin : g_rev
        assign n_o[i] = k_i[LOG2_N-1-i];
    end
`else
    assign n_o = k_i;
`endif
endmodule

// File: rtl/bitrev_frame_reader.sv
// bitrev_frame_reader: snapshots a full 128-sample frame and streams it to the FFT core (order set by BITREV_ORDER_EN)
module bitrev_frame_reader
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             shift_in,
    input  logic [127:0][7:0] frame_in,
    output logic [7:0]       out_data,
    output logic [6:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);
    localparam logic [7:0] FILL_FULL = 8'(N_PTS);
    localparam idx_t       K_LAST    = idx_t'(N_PTS - 1);

    rd_state_t  state_q;
    logic [7:0] fill_q, fill_d;
    idx_t       k_q, map_n;
    frame_t     snap_q;
    logic       out_valid_q, out_last_q, frame_done_q, busy_q, overrun_q;
    logic       full, capture, beat;

    assign full    = fill_q == FILL_FULL;
    assign capture = state_q == IDLE && full;
    assign beat    = out_valid_q && out_ready;

    // Capture restarts the count, keeping a sample that lands on the capture edge
    always_comb begin
        fill_d = capture ? {7'd0, shift_in} : (shift_in && !full) ? fill_q + 8'd1 : fill_q;
    end

    // Fill counter of samples loaded since the last capture
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) fill_q <= '0;
        else        fill_q <= fill_d;
    end

    // Frame snapshot, frozen for the whole stream
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)       snap_q <= '0;
        else if (capture) snap_q <= frame_in;
    end

    // Sticky overrun: a full buffer keeps loading while the previous frame is still busy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) overrun_q <= 1'b0;
        else        overrun_q <= (shift_in && full && state_q != IDLE) || (overrun_q && !clr_ovr);
    end

    // Reader FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (capture) begin
                    state_q     <= STREAM;
                    k_q         <= '0;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b1;
                end
                STREAM: if (beat) begin
                    k_q <= k_q + idx_t'(1);
                    if (k_q == K_LAST) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b0;
                        out_last_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        out_last_q <= k_q == K_LAST - idx_t'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fft_index_map u_map (
        .k_i (k_q),
        .n_o (map_n)
    );

    // Entry 127 holds time 0, so the time index is mirrored into the buffer index
    assign out_data   = snap_q[K_LAST - map_n];
    assign out_idx    = k_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
endmodule

// File: doc/bitrev_frame_reader.md
BITREV_FRAME_READER -- requirements
Module: bitrev_frame_reader

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 n_rst  input  1  reset, asynchronous, active-low.
REQ-003 shift_in  input  1  same strobe that drives the loading buffer; one new sample per high cycle.
REQ-004 frame_in  input  128x8 (packed [127:0][7:0])  loading buffer contents; entry 0 newest, entry 127 oldest.
REQ-005 out_data  output  8  current streamed sample.
REQ-006 out_idx  output  7  output beat number k, 0..127.
REQ-007 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-008 out_ready  input  1  downstream FFT core accepts beat.
REQ-009 out_last  output  1  high with valid on beat k=127.
REQ-010 frame_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-011 busy  output  1  high in STREAM and DONE.
REQ-012 overrun  output  1  sticky lost-frame flag.
REQ-013 clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-014 Time index n of buffer entry i SHALL be n = 127 - i (n=0 oldest).
REQ-015 Fill counter SHALL increment on shift_in, saturate at 128, and be 8 bits wide.
REQ-016 FSM states SHALL be IDLE, STREAM, DONE.
REQ-017 IDLE->STREAM SHALL occur when fill==128; on that edge frame_in is copied into a 128x8 snapshot, k=0, fill=0.
REQ-018 A shift_in in the capture cycle SHALL be excluded from the snapshot and SHALL leave fill=1 after the edge.
REQ-019 out_valid SHALL be registered, high exactly while in STREAM; first valid beat in the cycle after capture.
REQ-020 out_data SHALL be snapshot[127 - map(k)], where map is bit-reverse of the 7-bit k (REQ-030).
REQ-021 A beat transfers when out_valid && out_ready; k increments by 1 per transfer.
REQ-022 out_data, out_idx, out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 Transfer with k==127 SHALL move to DONE; DONE lasts one cycle with frame_done=1, then IDLE.
REQ-024 A new capture SHALL NOT occur in STREAM or DONE; earliest recapture is the first IDLE cycle with fill==128.
REQ-025 overrun SHALL set when shift_in is high while fill==128 and state is not IDLE; it stays set until clr_ovr.
REQ-026 clr_ovr and a set condition in the same cycle SHALL leave overrun set.
REQ-027 Snapshot SHALL be unaffected by frame_in changes during STREAM.

Reset
REQ-028 On n_rst low: state=IDLE, fill=0, k=0, out_valid=0, out_last=0, frame_done=0, busy=0, overrun=0, out_idx=0, out_data=0, snapshot=0.
REQ-029 Reset asserted mid-STREAM SHALL abort the frame immediately with no frame_done; after release a full 128-sample refill is required.

Configuration
REQ-030 With BITREV_ORDER_EN defined, map(k) SHALL be bit-reverse(k) over 7 bits; undefined, map(k)=k (natural time order). All handshake and timing behaviour SHALL be identical in both builds.

Structure
REQ-031 Shared package fft_pkg SHALL hold N_PTS=128, LOG2_N=7, SAMPLE_W=8, the sample/frame typedefs, and the reader state enum.
REQ-032 Index mapping SHALL be a sub-module fft_index_map (7-bit in, 7-bit out, combinational), parameterised by the macro.

Verification
REQ-033 Ramp: shift_in 0..127 (128 pulses), out_ready=1 -> BITREV_ORDER_EN: beats k=0,1,2,3 give out_data 0,64,32,96; natural build: 0,1,2,3; out_last at k=127; frame_done one cycle later.
REQ-034 Backpressure: out_ready low for 5 cycles at k=10 -> out_idx=10 and out_data held constant for those 5 cycles, no beat lost.
REQ-035 Capture collision: 129th shift_in (value 0xAA) in capture cycle -> 0xAA absent from frame, fill=1 after capture.
REQ-036 Overrun: 128 further shift_in pulses during a stalled STREAM (out_ready=0), then one more -> overrun=1; clr_ovr pulse -> 0.
REQ-037 Reset at k=50 -> out_valid=0 next cycle, no frame_done, no capture until 128 new shift_in pulses.
REQ-038 Back-to-back: 128 shift_in pulses arriving during STREAM -> capture on the first IDLE cycle after DONE, overrun stays 0.
